coeff_addr_sched: RTL

Address scheduler for the per-stage twiddle-coefficient ROMs of the 128-point, 4-lane parallel FFT. It replaces the free-running per-ROM counters with one frame-aware counter: it tracks input start-of-frame (SOP) and valid, generates a 5-bit ROM address plus read enable for each of the 7 stages, and skews each stage's address stream by the stage datapath latency. This keeps coefficients aligned with data through stalls, frame restarts and reset.

---
 rtl/coeff_addr_sched_pkg.sv | 24 ++
 rtl/coeff_addr_sched_if.sv | 41 ++++
 rtl/coeff_addr_sched_token_delay.sv | 39 +++
 rtl/coeff_addr_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/coeff_addr_sched_pkg.sv
// Shared constants and types for the FFT twiddle-coefficient ROM address scheduler.
package fft_coeff_pkg;

  localparam int unsigned N_POINTS      = 128;
  localparam int unsigned LANES         = 4;
  localparam int unsigned STAGES        = $clog2(N_POINTS);
  localparam int unsigned ADDR_W        = $clog2(N_POINTS / LANES);
  localparam int unsigned COEFF_W       = 11;
  localparam int unsigned STAGE_LAT_DEF = 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic              en;
    logic              sop;
    logic [ADDR_W-1:0] addr;
  } token_t;

endpackage

// File: rtl/coeff_addr_sched_if.sv
// Input handshake and per-stage ROM address bundle of the coefficient scheduler.
// COEFF_SEQ_STATS_EN adds the frame_cnt / err_cnt statistics outputs.
interface coeff_addr_sched_if;
  import fft_coeff_pkg::*;

  logic                     in_valid;
  logic                     in_sop;
  logic [STAGES*ADDR_W-1:0] stage_addr;
  logic [STAGES-1:0]        stage_en;
  logic [STAGES-1:0]        stage_sop;
  logic                     frame_done;
  logic                     busy;
  logic                     sop_err;
`ifdef COEFF_SEQ_STATS_EN
  logic [15:0]              frame_cnt;
  logic [7:0]               err_cnt;

  modport master (
    output in_valid, in_sop,
    input  stage_addr, stage_en, stage_sop, frame_done, busy, sop_err,
    input  frame_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_sop,
    output stage_addr, stage_en, stage_sop, frame_done, busy, sop_err,
    output frame_cnt, err_cnt
  );
`else
  modport master (
    output in_valid, in_sop,
    input  stage_addr, stage_en, stage_sop, frame_done, busy, sop_err
  );

  modport slave (
    input  in_valid, in_sop,
    output stage_addr, stage_en, stage_sop, frame_done, busy, sop_err
  );
`endif

endinterface

// File: rtl/coeff_addr_sched_token_delay.sv
// DEPTH-cycle shift register of coefficient tokens with synchronous clear;
// any_en reports whether any stored token is still enabled.
module coeff_token_delay
  import fft_coeff_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  token_t din,
  output token_t dout,
  output logic   any_en
);

  token_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    any_en = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_en = any_en | pipe[i].en;
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/coeff_addr_sched.sv
// Frame-aware twiddle ROM address scheduler: one base counter, per-stage skewed tokens.
// Optional build macro COEFF_SEQ_STATS_EN adds frame_cnt / err_cnt counters.
module coeff_addr_sched
  import fft_coeff_pkg::*;
#(
  parameter int unsigned STAGE_LAT = STAGE_LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  coeff_addr_sched_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              sop_err_q;
  token_t            tok0;
  token_t            tok [STAGES];
  logic [STAGES-1:0] dly_en;
  logic              frame_done;

  // Idle cycles keep the previous address in tok0, so held addresses ride the
  // delay line and every stage_addr holds its last value through gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tok0      <= '0;
      sop_err_q <= 1'b0;
    end else begin
      sop_err_q <= 1'b0;
      tok0.en   <= 1'b0;
      tok0.sop  <= 1'b0;
      if (bus.in_valid) begin
        unique case (state)
          IDLE: begin
            if (bus.in_sop) begin
              tok0  <= '{en: 1'b1, sop: 1'b1, addr: '0};
              cnt   <= ADDR_W'(1);
              state <= RUN;
            end else begin
              sop_err_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.in_sop) begin
              sop_err_q <= (cnt != '0);
              tok0      <= '{en: 1'b1, sop: 1'b1, addr: '0};
              cnt       <= ADDR_W'(1);
            end else begin
              tok0 <= '{en: 1'b1, sop: 1'b0, addr: cnt};
              cnt  <= cnt + 1'b1;
              if (cnt == LAST_ADDR) begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tok[0]    = tok0;
  assign dly_en[0] = tok0.en;

  for (genvar s = 1; s < STAGES; s++) begin : g_stage
    coeff_token_delay #(
      .DEPTH(STAGE_LAT)
    ) u_delay (
      .clk   (clk),
      .rst   (rst),
      .din   (tok[s-1]),
      .dout  (tok[s]),
      .any_en(dly_en[s])
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_out
    assign bus.stage_addr[s*ADDR_W +: ADDR_W] = tok[s].addr;
    assign bus.stage_en[s]                    = tok[s].en;
    assign bus.stage_sop[s]                   = tok[s].sop;
  end

  assign frame_done     = tok[STAGES-1].en & (tok[STAGES-1].addr == LAST_ADDR);
  assign bus.frame_done = frame_done;
  assign bus.busy       = (state == RUN) | (|dly_en);
  assign bus.sop_err    = sop_err_q;

`ifdef COEFF_SEQ_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (sop_err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
`endif

endmodule
